// File: rtl/hermes_local_mux_pkg.sv
// hermes_local_mux_pkg: shared FSM state type and index-width helper for the local mux.
package hermes_local_mux_pkg;
   typedef enum logic {IDLE, LOCKED} mux_state_t;

   function automatic int src_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/hermes_skid_buffer.sv
// hermes_skid_buffer: 2-entry FIFO with registered ready, cutting the sink-ready to source-ready path.
module hermes_skid_buffer #(
   parameter int DATA_SIZE = 33
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx_i,
   output logic                 rx_ack_o,
   input  logic [DATA_SIZE-1:0] data_i,
   output logic                 tx_o,
   input  logic                 tx_ack_i,
   output logic [DATA_SIZE-1:0] data_o
);
   logic [1:0]           r_cnt, w_cnt_n, w_idx;
   logic [DATA_SIZE-1:0] r_d0, r_d1;
   logic                 r_ready, w_push, w_pop;

   assign rx_ack_o = r_ready;
   assign tx_o     = r_cnt != 2'd0;
   assign data_o   = r_d0;
   assign w_push   = rx_i && r_ready;
   assign w_pop    = tx_o && tx_ack_i;
   assign w_cnt_n  = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
   // slot the incoming entry lands in after this cycle's pop shifts the tail forward
   assign w_idx    = r_cnt - {1'b0, w_pop};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt   <= '0;
         r_ready <= 1'b1;
         r_d0    <= '0;
         r_d1    <= '0;
      end else begin
         r_cnt   <= w_cnt_n;
         r_ready <= w_cnt_n != 2'd2;
         if (w_pop) r_d0 <= r_d1;
         if (w_push && w_idx == 2'd0) r_d0 <= data_i;
         if (w_push && w_idx == 2'd1) r_d1 <= data_i;
      end
   end
endmodule

// File: rtl/hermes_local_mux.sv
// hermes_local_mux: packet-granular round-robin mux of N_SRC Hermes senders onto the router local port.
module hermes_local_mux
   import hermes_local_mux_pkg::*;
#(
   parameter int FLIT_SIZE = 32,
   parameter int N_SRC     = 2,
   parameter int CNT_W     = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [N_SRC-1:0]           src_tx_i,
   input  logic [N_SRC-1:0]           src_eop_i,
   input  logic [N_SRC*FLIT_SIZE-1:0] src_data_i,
   output logic [N_SRC-1:0]           src_credit_o,
   output logic                       noc_tx_o,
   output logic                       noc_eop_o,
   output logic [FLIT_SIZE-1:0]       noc_data_o,
   input  logic                       noc_credit_i,
   output logic [N_SRC*CNT_W-1:0]     pkt_cnt_o,
   output logic                       busy_o
);
   localparam int SRC_W = src_w(N_SRC);

   mux_state_t           r_state, w_state_n;
   logic [SRC_W-1:0]     r_owner, r_last, w_gnt, w_k;
   logic [CNT_W-1:0]     r_pkt_cnt [N_SRC];
   logic                 w_ready, w_acc, w_eop, w_req;
   logic [FLIT_SIZE-1:0] w_data;

   assign w_req        = (r_state == IDLE) && |src_tx_i;
   assign w_eop        = src_eop_i[r_owner];
   assign w_data       = src_data_i[int'(r_owner)*FLIT_SIZE +: FLIT_SIZE];
   assign w_acc        = (r_state == LOCKED) && src_tx_i[r_owner] && w_ready;
   assign src_credit_o = (r_state == LOCKED) ? (N_SRC'(w_ready) << r_owner) : '0;
   assign busy_o       = (r_state == LOCKED) || noc_tx_o;

   // searched from farthest to nearest so the first requester after r_last wins
   always_comb begin
      w_gnt = r_last;
      w_k   = r_last;
      for (int i = N_SRC; i >= 1; i--) begin
         w_k = SRC_W'((int'(r_last) + i) % N_SRC);
         if (src_tx_i[w_k]) w_gnt = w_k;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_n;
   end

   always_comb begin
      w_state_n = r_state;
      if (w_req) w_state_n = LOCKED;
      if (w_acc && w_eop) w_state_n = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_owner <= '0;
         r_last  <= SRC_W'(N_SRC - 1);
         for (int i = 0; i < N_SRC; i++) r_pkt_cnt[i] <= '0;
      end else begin
         if (w_req) r_owner <= w_gnt;
         if (w_acc && w_eop) begin
            r_last             <= r_owner;
            r_pkt_cnt[r_owner] <= r_pkt_cnt[r_owner] + CNT_W'(1);
         end
      end
   end

   for (genvar g = 0; g < N_SRC; g++) begin : g_cnt
      assign pkt_cnt_o[g*CNT_W +: CNT_W] = r_pkt_cnt[g];
   end

   hermes_skid_buffer #(
      .DATA_SIZE(FLIT_SIZE + 1)
   ) u_skid (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .rx_i    (w_acc),
      .rx_ack_o(w_ready),
      .data_i  ({w_eop, w_data}),
      .tx_o    (noc_tx_o),
      .tx_ack_i(noc_credit_i),
      .data_o  ({noc_eop_o, noc_data_o})
   );
endmodule

// File: tb/tb_hermes_local_mux.sv
// tb_hermes_local_mux: directed scoreboard bench for the local mux (8-bit counters to reach wrap quickly).
module tb_hermes_local_mux;
   localparam int FS = 32;
   localparam int NS = 2;
   localparam int CW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_ni;
   logic [NS-1:0]     src_tx, src_eop, src_credit;
   logic [NS*FS-1:0]  src_data;
   logic              noc_tx, noc_eop, noc_credit, busy;
   logic [FS-1:0]     noc_data, head;
   logic [NS*CW-1:0]  pkt_cnt;
   logic [FS:0]       q0[$], q1[$], sb[$];
   logic              a0, a1, hold0;
   logic [CW-1:0]     ec0, ec1;
   int                vec = 0, err = 0, acc = 0, outn = 0, k, n, base;

   hermes_local_mux #(.FLIT_SIZE(FS), .N_SRC(NS), .CNT_W(CW)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .src_tx_i    (src_tx),
      .src_eop_i   (src_eop),
      .src_data_i  (src_data),
      .src_credit_o(src_credit),
      .noc_tx_o    (noc_tx),
      .noc_eop_o   (noc_eop),
      .noc_data_o  (noc_data),
      .noc_credit_i(noc_credit),
      .pkt_cnt_o   (pkt_cnt),
      .busy_o      (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic enq(input int s, input int cnt, input logic [FS-1:0] b, input bit to_sb);
      logic [FS:0] f;
      for (int i = 0; i < cnt; i++) begin
         f = {i == cnt - 1, b + FS'(i)};
         if (s == 0) q0.push_back(f);
         else        q1.push_back(f);
         if (to_sb) sb.push_back(f);
      end
   endtask

   // one clock: monitor and handshake sampling at negedge, source update just after posedge
   task automatic tick();
      logic [FS:0] e;
      @(negedge clk);
      if (noc_tx && noc_credit) begin
         outn++;
         if (sb.size() == 0) chk("sb_has_entry", 64'(sb.size()), 1);
         else begin
            e = sb.pop_front();
            chk("flit", {noc_eop, noc_data}, e);
         end
      end
      a0 = src_tx[0] & src_credit[0];
      a1 = src_tx[1] & src_credit[1];
      @(posedge clk);
      #1;
      if (!rst_ni) begin
         a0 = 1'b0;
         a1 = 1'b0;
      end
      if (a0) begin void'(q0.pop_front()); acc++; end
      if (a1) begin void'(q1.pop_front()); acc++; end
      src_tx[0] = (q0.size() != 0) && !hold0;
      {src_eop[0], src_data[FS-1:0]} = (q0.size() != 0) ? q0[0] : '0;
      src_tx[1] = q1.size() != 0;
      {src_eop[1], src_data[2*FS-1:FS]} = (q1.size() != 0) ? q1[0] : '0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int c = 0;
      do begin
         tick();
         c++;
      end while (!(busy == 1'b0 && q0.size() == 0 && q1.size() == 0 && src_tx == '0) && c < budget);
      chk({tag, "_timeout"}, 64'(c < budget), 1);
      chk({tag, "_drain"}, 64'(sb.size()), 0);
   endtask

   initial begin
      rst_ni = 1'b0; src_tx = '0; src_eop = '0; src_data = '0;
      noc_credit = 1'b1; hold0 = 1'b0; a0 = 1'b0; a1 = 1'b0; ec0 = '0; ec1 = '0;
      #1;
      chk("rst_noc_tx", noc_tx, 0);
      chk("rst_noc_eop", noc_eop, 0);
      chk("rst_noc_data", noc_data, 0);
      chk("rst_src_credit", src_credit, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      tick(); tick();
      rst_ni = 1'b1;
      tick();

      // simultaneous requests: source 0 first out of reset, then alternate per packet
      enq(0, 1, 'h10, 0); enq(0, 1, 'h11, 0);
      enq(1, 1, 'h20, 0); enq(1, 1, 'h21, 0);
      sb.push_back({1'b1, 32'h10}); sb.push_back({1'b1, 32'h20});
      sb.push_back({1'b1, 32'h11}); sb.push_back({1'b1, 32'h21});
      wait_idle("arb", 40);
      ec0 += 2; ec1 += 2;
      chk("arb_cnt", pkt_cnt, {ec1, ec0});

      // 3-flit packet latency and throughput
      enq(0, 3, 'hA0, 1);
      tick();
      chk("lat_req_busy", busy, 0);
      chk("lat_c0_tx", noc_tx, 0);
      tick();
      chk("lat_grant_credit", src_credit, 2'b01);
      chk("lat_c1_tx", noc_tx, 0);
      chk("lat_c1_busy", busy, 1);
      tick(); chk("lat_c2_tx", noc_tx, 1);
      tick(); chk("lat_c3_tx", noc_tx, 1);
      tick(); chk("lat_c4_tx", noc_tx, 1); chk("lat_eop", noc_eop, 1);
      tick(); chk("lat_c5_tx", noc_tx, 0);
      ec0++;
      chk("lat_cnt0", pkt_cnt[CW-1:0], ec0);
      chk("lat_busy_drop", busy, 0);

      // router backpressure mid-packet
      enq(0, 6, 'h30, 1);
      k = 0;
      do begin tick(); k++; end while (!noc_tx && k < 20);
      chk("stall_start_timeout", 64'(k < 20), 1);
      noc_credit = 1'b0;
      head = noc_data;
      chk("stall_head0", head, 'h30);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_head", noc_data, head);
         chk("stall_tx", noc_tx, 1);
      end
      chk("stall_credit", src_credit, 0);
      chk("stall_depth", 64'((acc - outn) <= 2), 1);
      noc_credit = 1'b1;
      wait_idle("stall", 40);
      ec0++;

      // owner pauses mid-packet while source 1 waits
      base = acc;
      enq(0, 4, 'h40, 1);
      k = 0;
      do begin tick(); k++; end while (acc < base + 2 && k < 20);
      chk("hold_start_timeout", 64'(k < 20), 1);
      hold0 = 1'b1;
      enq(1, 2, 'h50, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("hold_src1_credit", src_credit[1], 0);
         chk("hold_busy", busy, 1);
      end
      hold0 = 1'b0;
      wait_idle("hold", 40);
      ec0++; ec1++;
      chk("hold_cnt", pkt_cnt, {ec1, ec0});

      // counter wrap on source 1
      n = 254 - int'(ec1);
      for (int i = 0; i < n; i++) enq(1, 1, $urandom, 1);
      wait_idle("wrap_fill", 4 * n + 50);
      ec1 = ec1 + CW'(n);
      chk("wrap_fe", pkt_cnt[2*CW-1:CW], 8'hFE);
      enq(1, 1, 'hE1, 1);
      wait_idle("wrap_ff_pkt", 20);
      ec1++;
      chk("wrap_ff", pkt_cnt[2*CW-1:CW], 8'hFF);
      enq(1, 1, 'hE2, 1);
      wait_idle("wrap_00_pkt", 20);
      ec1++;
      chk("wrap_00", pkt_cnt[2*CW-1:CW], ec1);
      chk("wrap_cnt0", pkt_cnt[CW-1:0], ec0);

      // reset with a locked packet and a full skid buffer
      noc_credit = 1'b0;
      base = acc;
      enq(0, 6, 'hC0, 0);
      k = 0;
      do begin tick(); k++; end while (!(acc == base + 2 && src_credit == '0) && k < 20);
      chk("rst_fill_timeout", 64'(k < 20), 1);
      chk("rst_fill_tx", noc_tx, 1);
      #2 rst_ni = 1'b0;
      #1;
      chk("rst_mid_tx", noc_tx, 0);
      chk("rst_mid_credit", src_credit, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_cnt", pkt_cnt, 0);
      q0.delete(); q1.delete(); sb.delete();
      ec0 = '0; ec1 = '0;
      tick(); tick();
      rst_ni = 1'b1;
      noc_credit = 1'b1;
      enq(0, 1, 'h60, 1);
      enq(1, 1, 'h70, 1);
      tick(); tick();
      chk("rst_first_grant", src_credit, 2'b01);
      wait_idle("rst_after", 40);
      ec0++; ec1++;
      chk("rst_after_cnt", pkt_cnt, {ec1, ec0});

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
